// File: rtl/slave_interface.sv
// Serial-bus slave: collects an LSB-first address (and write data) from a
// one-bit bus, issues a single memory write or read strobe, and returns read
// data LSB-first on a one-bit serial output.
module slave_interface #(
  parameter int DATA_WIDTH           = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            swdata,
  input  logic                            smode,
  input  logic                            swvalid,
  output logic                            srdata,
  output logic                            srvalid,
  output logic                            sready,
  output logic [SLAVE_MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic                            mem_wen,
  output logic                            mem_ren,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_rvalid
);

  localparam int AW       = SLAVE_MEM_ADDR_WIDTH;
  localparam int DW       = DATA_WIDTH;
  localparam int MAX_BITS = (AW > DW) ? AW : DW;
  localparam int CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(AW - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    READ,
    WAIT,
    SEND
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // index of the next bit within the current phase
  logic             mode_q, mode_d;   // latched smode of the current transfer
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d; // read data, shifted out from bit 0

  // State register; reset lands in IDLE so sready rises at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Datapath registers: bit counter, latched mode, address/data shifters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and datapath update; serial bits shift in from the MSB end so
  // the first (LSB) bit ends up at position 0 after a full phase.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (swvalid) begin
          addr_d  = {swdata, addr_q[AW-1:1]};
          mode_d  = smode;
          cnt_d   = CNT_ONE;
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (swvalid) begin
          addr_d = {swdata, addr_q[AW-1:1]};
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? WDATA : READ;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      WDATA: begin
        if (swvalid) begin
          wdata_d = {swdata, wdata_q[DW-1:1]};
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      WRITE: state_d = IDLE;

      READ: state_d = WAIT;

      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        rdata_d = rdata_q >> 1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Strobes and handshake outputs decode directly from the state.
  assign sready    = (state_q == IDLE);
  assign mem_wen   = (state_q == WRITE);
  assign mem_ren   = (state_q == READ);
  assign srvalid   = (state_q == SEND);
  assign srdata    = (state_q == SEND) & rdata_q[0];
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_slave_interface.sv
// Randomized scoreboard bench for slave_interface: stimulus tasks push the
// expected memory strobes and serial read bits; a negedge monitor pops them.
module tb_slave_interface;

  localparam int DW = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          swdata = 1'b0;
  logic          smode = 1'b0;
  logic          swvalid = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          srdata, srvalid, sready, mem_wen, mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  wr_exp_t       wr_q[$];
  logic [AW-1:0] rd_q[$];
  logic          bits_q[$];

  slave_interface #(
    .DATA_WIDTH          (DW),
    .SLAVE_MEM_ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .swdata    (swdata),
    .smode     (smode),
    .swvalid   (swvalid),
    .srdata    (srdata),
    .srvalid   (srvalid),
    .sready    (sready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every strobe or serial bit the DUT presents must match the head
  // of the matching expectation queue.
  always @(negedge clk) begin
    wr_exp_t e;
    logic    b;
    if (!rst) begin
      if (mem_wen) begin
        if (wr_q.size() == 0) check("wr_unexpected", mem_wen, 0);
        else begin
          e = wr_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
        end
      end
      if (mem_ren) begin
        if (rd_q.size() == 0) check("rd_unexpected", mem_ren, 0);
        else check("rd_addr", mem_addr, rd_q.pop_front());
      end
      if (srvalid) begin
        if (bits_q.size() == 0) check("srvalid_unexpected", srvalid, 0);
        else begin
          b = bits_q.pop_front();
          check("rd_bit", srdata, b);
        end
      end else begin
        check("srdata_idle_zero", srdata, 0);
      end
    end
  end

  task automatic drive_bit(input logic b, input logic m, input int gap);
    swvalid = 1'b1;
    swdata  = b;
    smode   = m;
    @(posedge clk); #1;
    swvalid = 1'b0;
    swdata  = 1'($urandom);
    smode   = 1'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_addr(input logic [AW-1:0] a, input logic m, input int gap, input bit last_gap);
    for (int i = 0; i < AW; i++)
      drive_bit(a[i], (i == 0) ? m : 1'($urandom), (i == AW - 1 && !last_gap) ? 0 : gap);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
    check("wr_sready_start", sready, 1);
    wr_q.push_back('{a, d});
    send_addr(a, 1'b1, gap, 1'b1);
    for (int i = 0; i < DW; i++)
      drive_bit(d[i], 1'($urandom), (i == DW - 1) ? 0 : gap);
    check("wr_latency", mem_wen, 1);
    @(posedge clk); #1;
    check("wr_single_pulse", mem_wen, 0);
    check("wr_sready_back", sready, 1);
    check("wr_addr_hold", mem_addr, a);
    check("wr_data_hold", mem_wdata, d);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap,
                         input int lat, input bit toggle);
    check("rd_sready_start", sready, 1);
    rd_q.push_back(a);
    for (int i = 0; i < DW; i++) bits_q.push_back(d[i]);
    send_addr(a, 1'b0, gap, 1'b0);
    check("rd_latency", mem_ren, 1);
    for (int i = 0; i < lat; i++) begin
      swvalid = toggle ? 1'($urandom) : 1'b0;
      swdata  = 1'($urandom);
      @(posedge clk); #1;
      check("rd_single_pulse", mem_ren, 0);
      check("rd_wait_no_send", srvalid, 0);
    end
    swvalid    = toggle ? 1'($urandom) : 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = DW'($urandom);
    check("rd_send_latency", srvalid, 1);
    for (int i = 0; i < DW - 1; i++) begin
      swvalid    = toggle ? 1'($urandom) : 1'b0;
      swdata     = 1'($urandom);
      mem_rvalid = toggle ? 1'($urandom) : 1'b0;
      mem_rdata  = DW'($urandom);
      @(posedge clk); #1;
    end
    swvalid    = 1'b0;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("rd_done_sready", sready, 1);
    check("rd_done_srvalid", srvalid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sready"}, sready, 1);
    check({tag, "_srvalid"}, srvalid, 0);
    check({tag, "_srdata"}, srdata, 0);
    check({tag, "_wen"}, mem_wen, 0);
    check({tag, "_ren"}, mem_ren, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed write, continuous bits.
    do_write(12'h2A5, 8'hA3, 0);
    // Directed read, memory answers three cycles after the strobe.
    do_read(12'hAAA, 8'h96, 0, 3, 1'b0);
    // Write with two idle cycles between every bit.
    do_write(12'h001, 8'hFF, 2);

    // Abort a write after five address bits, then a clean write.
    check("abort_sready", sready, 1);
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom), (i == 0) ? 1'b1 : 1'($urandom), 0);
    pulse_reset("abort_wr");
    do_write(12'h3C0, 8'h5A, 0);

    // Read with swvalid and mem_rvalid noise during WAIT and SEND.
    do_read(12'h5C3, 8'h81, 0, 2, 1'b1);

    // Back-to-back write then read.
    do_write(12'h7E1, 8'h3C, 0);
    do_read(12'h123, 8'h4B, 0, 1, 1'b0);

    // Abort a read while waiting on memory; a stray mem_rvalid in IDLE is ignored.
    check("abort_rd_sready", sready, 1);
    rd_q.push_back(12'hF0F);
    send_addr(12'hF0F, 1'b0, 0, 1'b0);
    check("abort_rd_ren", mem_ren, 1);
    @(posedge clk); #1;
    pulse_reset("abort_rd");
    mem_rvalid = 1'b1;
    mem_rdata  = 8'hFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("stray_rvalid_idle", sready, 1);
    check("stray_rvalid_srvalid", srvalid, 0);

    // Randomized mix of transfers.
    for (int n = 0; n < 24; n++) begin
      a = AW'($urandom);
      d = DW'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, $urandom_range(0, 2));
      else
        do_read(a, d, $urandom_range(0, 2), $urandom_range(1, 5), 1'($urandom));
    end

    repeat (3) begin @(posedge clk); #1; end
    check("sb_wr_drained", wr_q.size(), 0);
    check("sb_rd_drained", rd_q.size(), 0);
    check("sb_bits_drained", bits_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
